// File: rtl/dco_nco_bank.sv
// dco_nco_bank: NCH phase-accumulator oscillators sharing one configuration write port.
// Define DCO_NCO_GLIDE_EN to make writes glide the frequency code toward its target.
module dco_nco_ch #(
   parameter int CODE_W     = 8,
   parameter int ACC_W      = 16,
   parameter int GLIDE_STEP = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              wr,
   input  logic [CODE_W-1:0] wr_code,
   input  logic [1:0]        wr_mode,
   input  logic              wr_clr,
   output logic              dco,
   output logic              busy
);
   logic [ACC_W-1:0]  acc;
   logic [CODE_W-1:0] cur, tgt;
   logic [1:0]        mode;
   logic [ACC_W:0]    sum;
   logic              adv;

   assign adv  = ena && (mode != 2'b00) && (cur != '0);
   assign sum  = {1'b0, acc} + (ACC_W+1)'(cur);
   // Without glide cur and tgt are always written together, so this stays 0.
   assign busy = (cur != tgt);

`ifdef DCO_NCO_GLIDE_EN
   localparam logic [CODE_W-1:0] STEP = CODE_W'(GLIDE_STEP);
   logic [CODE_W-1:0] cur_nxt;

   always_comb begin
      cur_nxt = cur;
      if (tgt > cur)      cur_nxt = (tgt - cur > STEP) ? cur + STEP : tgt;
      else if (cur > tgt) cur_nxt = (cur - tgt > STEP) ? cur - STEP : tgt;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         cur  <= '0;
         tgt  <= '0;
         mode <= 2'b00;
         dco  <= 1'b0;
      end else begin
         if (adv) acc <= sum[ACC_W-1:0];
         // Square modes hold while stalled; the pulse mode only fires on a real carry.
         case (mode)
            2'b00:   dco <= 1'b0;
            2'b01:   if (adv) dco <= acc[ACC_W-1];
            2'b11:   if (adv) dco <= ~acc[ACC_W-1];
            default: dco <= adv & sum[ACC_W];
         endcase
`ifdef DCO_NCO_GLIDE_EN
         cur <= cur_nxt;
         if (wr) begin
            tgt  <= wr_code;
            mode <= wr_mode;
         end
`else
         if (wr) begin
            cur  <= wr_code;
            tgt  <= wr_code;
            mode <= wr_mode;
         end
`endif
         if (wr && wr_clr) acc <= '0;
      end
   end
endmodule

module dco_nco_bank #(
   parameter int CODE_W     = 8,
   parameter int ACC_W      = 16,
   parameter int NCH        = 2,
   parameter int GLIDE_STEP = 1,
   localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CODE_W-1:0] wr_code,
   input  logic [1:0]        wr_mode,
   input  logic              wr_phase_clr,
   output logic [NCH-1:0]    dco_out,
   output logic [NCH-1:0]    busy
);
   logic rdy_q;
   logic accept;

   always_ff @(posedge clk) begin
      if (rst) rdy_q <= 1'b0;
      else     rdy_q <= 1'b1;
   end

`ifdef DCO_NCO_GLIDE_EN
   localparam int NPAD = 1 << CH_W;
   // Out-of-range channels read as idle so their writes still complete.
   logic [NPAD-1:0] busy_pad;
   assign busy_pad = NPAD'(busy);
   assign wr_ready = rdy_q && !busy_pad[wr_ch];
`else
   assign wr_ready = rdy_q;
`endif

   assign accept = wr_valid && wr_ready;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      dco_nco_ch #(
         .CODE_W    (CODE_W),
         .ACC_W     (ACC_W),
         .GLIDE_STEP(GLIDE_STEP)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .ena    (ena),
         .wr     (accept && (wr_ch == CH_W'(c))),
         .wr_code(wr_code),
         .wr_mode(wr_mode),
         .wr_clr (wr_phase_clr),
         .dco    (dco_out[c]),
         .busy   (busy[c])
      );
   end
endmodule

// File: tb/tb_dco_nco_bank.sv
// Bench for dco_nco_bank: pattern table, hand sequences and a random run checked
// every cycle against an arithmetic per-channel oscillator model.
module tb_dco_nco_bank;
   localparam int CODE_W = 8;
   localparam int ACC_W  = 8;
   localparam int NCH    = 2;
   localparam int MOD    = 1 << ACC_W;
   localparam int HALF   = MOD / 2;
   localparam int STEP   = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1, ena = 1'b0, wr_valid = 1'b0, wr_phase_clr = 1'b0;
   logic       wr_ready;
   logic       wr_ch = 1'b0;
   logic [7:0] wr_code = 8'h00;
   logic [1:0] wr_mode = 2'b00;
   logic [1:0] dco_out, busy;
   // Second bank with NCH=3 so an out-of-range channel (3) is addressable.
   logic       wr_valid3 = 1'b0, wr_ready3;
   logic [1:0] wr_ch3 = 2'd0;
   logic [2:0] dco3, busy3;

   int n_chk = 0, n_fail = 0;

   int m_acc[NCH], m_cur[NCH], m_tgt[NCH], m_mode[NCH];
   bit m_dco[NCH];
   bit m_rdy = 1'b0;

   always #5 clk = ~clk;

   dco_nco_bank #(.CODE_W(CODE_W), .ACC_W(ACC_W), .NCH(NCH), .GLIDE_STEP(STEP)) dut (
      .clk(clk), .rst(rst), .ena(ena), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_ch(wr_ch), .wr_code(wr_code), .wr_mode(wr_mode), .wr_phase_clr(wr_phase_clr),
      .dco_out(dco_out), .busy(busy));

   dco_nco_bank #(.CODE_W(CODE_W), .ACC_W(ACC_W), .NCH(3), .GLIDE_STEP(STEP)) dut3 (
      .clk(clk), .rst(rst), .ena(ena), .wr_valid(wr_valid3), .wr_ready(wr_ready3),
      .wr_ch(wr_ch3), .wr_code(wr_code), .wr_mode(wr_mode), .wr_phase_clr(wr_phase_clr),
      .dco_out(dco3), .busy(busy3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      bit r = m_rdy;
`ifdef DCO_NCO_GLIDE_EN
      if (int'(wr_ch) < NCH && m_cur[wr_ch] != m_tgt[wr_ch]) r = 1'b0;
`endif
      return r;
   endfunction

   // One clock of the oscillator rules, using the inputs present at the edge.
   task automatic model_step();
      bit take, adv;
      int sum;
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            m_acc[c] = 0; m_cur[c] = 0; m_tgt[c] = 0; m_mode[c] = 0; m_dco[c] = 1'b0;
         end
         m_rdy = 1'b0;
         return;
      end
      take = wr_valid && m_ready();
      for (int c = 0; c < NCH; c++) begin
         adv = ena && m_mode[c] != 0 && m_cur[c] != 0;
         sum = m_acc[c] + m_cur[c];
         case (m_mode[c])
            0: m_dco[c] = 1'b0;
            1: if (adv) m_dco[c] = (m_acc[c] >= HALF);
            3: if (adv) m_dco[c] = (m_acc[c] < HALF);
            default: m_dco[c] = adv && (sum >= MOD);
         endcase
         if (adv) m_acc[c] = sum % MOD;
`ifdef DCO_NCO_GLIDE_EN
         if (m_tgt[c] > m_cur[c])      m_cur[c] = (m_cur[c] + STEP > m_tgt[c]) ? m_tgt[c] : m_cur[c] + STEP;
         else if (m_tgt[c] < m_cur[c]) m_cur[c] = (m_cur[c] - STEP < m_tgt[c]) ? m_tgt[c] : m_cur[c] - STEP;
`endif
         if (take && int'(wr_ch) == c) begin
            m_tgt[c]  = int'(wr_code);
            m_mode[c] = int'(wr_mode);
`ifndef DCO_NCO_GLIDE_EN
            m_cur[c]  = int'(wr_code);
`endif
            if (wr_phase_clr) m_acc[c] = 0;
         end
      end
      m_rdy = 1'b1;
   endtask

   task automatic cmp_model();
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("model_dco%0d", c), 32'(dco_out[c]), 32'(m_dco[c]));
         chk($sformatf("model_busy%0d", c), 32'(busy[c]), 32'(m_cur[c] != m_tgt[c]));
      end
      chk("model_ready", 32'(wr_ready), 32'(m_ready()));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cmp_model();
   endtask

   task automatic write(input logic ch, input logic [7:0] code, input logic [1:0] mode, input logic clr);
      wr_valid = 1'b1; wr_ch = ch; wr_code = code; wr_mode = mode; wr_phase_clr = clr;
      tick();
      wr_valid = 1'b0; wr_phase_clr = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  code;
      logic [1:0]  mode;
      logic [15:0] pat;   // bit k = dco_out[0] sampled k+1 cycles after the write
   } vec_t;
   vec_t vt[10];

   initial begin
      logic [15:0] pat;
      logic [2:0]  other;
      int          cnt;

      vt[0] = '{8'h40, 2'b01, 16'hCCCC};
      vt[1] = '{8'h40, 2'b11, 16'h3333};
      vt[2] = '{8'h40, 2'b10, 16'h8888};
      vt[3] = '{8'h80, 2'b10, 16'hAAAA};
      vt[4] = '{8'h20, 2'b10, 16'h8080};
      vt[5] = '{8'h30, 2'b10, 16'h8420};
      vt[6] = '{8'h30, 2'b01, 16'hC738};
      vt[7] = '{8'h01, 2'b11, 16'hFFFF};
      vt[8] = '{8'h01, 2'b01, 16'h0000};
      vt[9] = '{8'h40, 2'b00, 16'h0000};

      // Reset: two cycles held, then release.
      @(negedge clk);
      tick();
      tick();
      chk("rst_dco", 32'(dco_out), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ready", 32'(wr_ready), 32'h0);
      rst = 1'b0;
      tick();
      chk("post_rst_ready", 32'(wr_ready), 32'h1);
      ena = 1'b1;

`ifndef DCO_NCO_GLIDE_EN
      foreach (vt[i]) begin
         write(1'b0, vt[i].code, vt[i].mode, 1'b1);
         pat = '0; other = '0;
         for (int k = 0; k < 16; k++) begin
            tick();
            pat[k] = dco_out[0];
            other[0] = other[0] | dco_out[1];
         end
         chk($sformatf("table%0d_pattern", i), 32'(pat), 32'(vt[i].pat));
         chk($sformatf("table%0d_ch1_idle", i), 32'(other[0]), 32'h0);
      end

      // Pulse mode, then ena low freezes the accumulator.
      write(1'b0, 8'h40, 2'b10, 1'b1);
      pat = '0;
      for (int k = 0; k < 5; k++) begin tick(); pat[k] = dco_out[0]; end
      chk("pulse_before_hold", 32'(pat), 32'h08);
      ena = 1'b0; cnt = 0;
      for (int k = 0; k < 10; k++) begin tick(); cnt += int'(dco_out[0]); end
      chk("pulses_while_ena_low", 32'(cnt), 32'h0);
      ena = 1'b1; pat = '0;
      for (int k = 0; k < 4; k++) begin tick(); pat[k] = dco_out[0]; end
      chk("pulse_after_resume", 32'(pat), 32'h4);
`endif

      // Out-of-range channel write on the three-channel bank.
      wr_valid3 = 1'b1; wr_ch3 = 2'd0; wr_code = 8'h40; wr_mode = 2'b01; wr_phase_clr = 1'b1;
      chk("oor_ready_ch0", 32'(wr_ready3), 32'h1);
      tick();
      wr_ch3 = 2'd3; wr_code = 8'h80; wr_mode = 2'b11;
      chk("oor_ready_ch3", 32'(wr_ready3), 32'h1);
      tick();
      wr_valid3 = 1'b0; wr_phase_clr = 1'b0;
      pat = '0; other = '0; pat[0] = dco3[0]; other[0] = |dco3[2:1];
      for (int k = 1; k < 16; k++) begin
         tick();
         pat[k] = dco3[0];
         other[0] = other[0] | (|dco3[2:1]) | (|busy3[2:1]);
      end
`ifndef DCO_NCO_GLIDE_EN
      chk("oor_ch0_pattern", 32'(pat), 32'hCCCC);
`endif
      chk("oor_other_channels", 32'(other[0]), 32'h0);
      chk("oor_ready_after", 32'(wr_ready3), 32'h1);

`ifdef DCO_NCO_GLIDE_EN
      write(1'b1, 8'h10, 2'b01, 1'b1);
      for (int k = 0; k < 16; k++) tick();
      chk("glide_settled", 32'(busy[1]), 32'h0);
      write(1'b1, 8'h14, 2'b01, 1'b0);
      cnt = int'(busy[1]);
      chk("glide_ready_ch1", 32'(wr_ready), 32'h0);
      wr_ch = 1'b0; #1;
      chk("glide_ready_ch0", 32'(wr_ready), 32'h1);
      wr_ch = 1'b1;
      for (int k = 0; k < 5; k++) begin tick(); cnt += int'(busy[1]); end
      chk("glide_busy_cycles", 32'(cnt), 32'd4);
`endif

      // Reset mid-run (mid-glide in the glide build).
      write(1'b1, 8'h40, 2'b01, 1'b1);
      for (int k = 0; k < 3; k++) tick();
      rst = 1'b1;
      tick();
      chk("midrst_dco", 32'(dco_out), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_ready", 32'(wr_ready), 32'h0);
      rst = 1'b0;
      tick();

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         wr_valid     = ($urandom_range(3) == 0);
         wr_ch        = 1'($urandom_range(1));
         wr_code      = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
         wr_mode      = 2'($urandom_range(3));
         wr_phase_clr = 1'($urandom_range(1));
         ena          = ($urandom_range(7) != 0);
         rst          = ($urandom_range(99) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
